// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the iterative DES key schedule:
//   - PC-1 / PC-2 permutation tables and functions (bit 1 = MSB, DES numbering)
//   - SHIFT_SCHED : per-round left-rotate amounts of the C/D halves
//   - rotl28 / rotr28 : 28-bit rotate by 1 or 2
//   - MODE_ENC / MODE_DEC key-order encodings
//   - state_t : key-schedule controller states
// -----------------------------------------------------------------------------
package des_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // 64-bit key -> {C0, D0}; parity bits (8, 16, ..., 64) are never selected.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TAB[i]];
    return cd;
  endfunction

  // {C, D} -> 48-bit round key, MSB = PC-2 output bit 1.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_TAB[i]];
    return k;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_sched_iter_if.sv
// -----------------------------------------------------------------------------
// des_key_sched_iter_if
// Job request and round-key stream between the key-load logic / round engine
// (master) and the iterative key scheduler (slave).
//   start, mode, key_in : job request, sampled when start && !busy
//   busy, done          : job status, done is a one-cycle pulse
//   rk_valid/rk_ready   : round-key handshake
//   rk_data, rk_round, rk_stage, rk_last : round key and its position
// -----------------------------------------------------------------------------
interface des_key_sched_iter_if #(
  parameter int NUM_KEYS = 1
);
  logic                    start;
  logic                    mode;
  logic [64*NUM_KEYS-1:0]  key_in;
  logic                    busy;
  logic                    rk_valid;
  logic                    rk_ready;
  logic [47:0]             rk_data;
  logic [3:0]              rk_round;
  logic [1:0]              rk_stage;
  logic                    rk_last;
  logic                    done;

  modport master (
    output start, mode, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, rk_stage, rk_last, done
  );

  modport slave (
    input  start, mode, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_round, rk_stage, rk_last, done
  );
endinterface

// File: rtl/des_ks_core.sv
// -----------------------------------------------------------------------------
// des_ks_core
// C/D half registers of the key schedule.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : load c_load/d_load (has priority over step)
//   c_load, d_load  : new C/D values
//   step            : rotate C and D together
//   dir             : MODE_ENC rotates left, MODE_DEC rotates right
//   amt             : rotate amount, 1 or 2
//   c_nxt, d_nxt    : value the registers take at the next edge, so the owner
//                     can register PC2 of it in the same cycle
// -----------------------------------------------------------------------------
module des_ks_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [27:0] c_load,
  input  logic [27:0] d_load,
  input  logic        step,
  input  logic        dir,
  input  logic [1:0]  amt,
  output logic [27:0] c_nxt,
  output logic [27:0] d_nxt
);

  logic [27:0] c_q;
  logic [27:0] d_q;

  // NOTE: every always_comb output gets a default first, so no path can hold a
  // stale value and infer a latch; combinational logic uses blocking '='.
  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (load) begin
      c_nxt = c_load;
      d_nxt = d_load;
    end else if (step) begin
      c_nxt = (dir == MODE_DEC) ? rotr28(c_q, amt) : rotl28(c_q, amt);
      d_nxt = (dir == MODE_DEC) ? rotr28(d_q, amt) : rotl28(d_q, amt);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      d_q <= '0;
    end else begin
      c_q <= c_nxt;
      d_q <= d_nxt;
    end
  end

endmodule

// File: rtl/des_key_sched_iter.sv
// -----------------------------------------------------------------------------
// des_key_sched_iter
// Iterative, back-pressured DES / 3DES round-key generator. A job captures
// NUM_KEYS keys and a mode on start, then streams 16*NUM_KEYS round keys, one
// per accepted rk_valid/rk_ready transfer, followed by a one-cycle done pulse.
//   clk, rst : clock, asynchronous active-high reset (aborts a running job)
//   bus      : des_key_sched_iter_if.slave (job request + round-key stream)
// NUM_KEYS: 1 = single DES, 3 = 3DES EDE.
// -----------------------------------------------------------------------------
module des_key_sched_iter
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  des_key_sched_iter_if.slave      bus
);

  state_t                  state;
  logic                    mode_q;
  logic [64*NUM_KEYS-1:0]  key_q;
  logic                    dir_q;     // rotate direction of the current stage
  logic [3:0]              round_q;
  logic [1:0]              stage_q;
  logic                    valid_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    done_q;
  logic [47:0]             data_q;

  logic                    start_ok;
  logic                    accept;
  logic                    stage_load;
  logic                    step;
  logic                    ld_mode;
  logic [1:0]              ld_stage;
  logic                    ld_dir;
  logic [64*NUM_KEYS-1:0]  key_src;
  logic [63:0]             ld_key;
  logic [55:0]             cd0;
  logic [27:0]             c_load;
  logic [27:0]             d_load;
  logic [1:0]              amt;
  logic [27:0]             c_nxt;
  logic [27:0]             d_nxt;
  int                      key_idx;

  assign start_ok   = (state == S_IDLE) && bus.start;
  assign accept     = valid_q && bus.rk_ready;
  assign stage_load = accept && (round_q == 4'd15) && !last_q;
  assign step       = accept && (round_q != 4'd15);

  // Configuration of the stage being loaded: stage 0 on start (straight from
  // the inputs), otherwise the stage after the current one. The middle 3DES
  // stage runs opposite to the job mode; decrypt jobs walk the keys backwards.
  always_comb begin
    ld_mode  = start_ok ? bus.mode   : mode_q;
    ld_stage = start_ok ? 2'd0       : stage_q + 2'd1;
    key_src  = start_ok ? bus.key_in : key_q;
    ld_dir   = ld_mode ^ ld_stage[0];
    key_idx  = (ld_mode == MODE_DEC) ? (NUM_KEYS - 1 - int'(ld_stage)) : int'(ld_stage);
    if (key_idx < 0 || key_idx >= NUM_KEYS) key_idx = 0;
    ld_key   = key_src[64*key_idx +: 64];
    cd0      = pc1(ld_key);
    // Encrypt starts at C1/D1; decrypt starts at C0/D0 == C16/D16.
    c_load   = (ld_dir == MODE_ENC) ? rotl28(cd0[55:28], 2'd1) : cd0[55:28];
    d_load   = (ld_dir == MODE_ENC) ? rotl28(cd0[27:0],  2'd1) : cd0[27:0];
    // Encrypt moves C(r+1)->C(r+2); decrypt undoes the shift that produced
    // the key just sent.
    amt      = (dir_q == MODE_DEC) ? SHIFT_SCHED[4'd15 - round_q]
                                   : SHIFT_SCHED[round_q + 4'd1];
  end

  des_ks_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok || stage_load),
    .c_load (c_load),
    .d_load (d_load),
    .step   (step),
    .dir    (dir_q),
    .amt    (amt),
    .c_nxt  (c_nxt),
    .d_nxt  (d_nxt)
  );

  // NOTE: the captured job operands are plain datapath registers with no
  // reset; they are only read while a job that loaded them is running.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      mode_q <= bus.mode;
      key_q  <= bus.key_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      dir_q   <= MODE_ENC;
      round_q <= '0;
      stage_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            dir_q   <= ld_dir;
            round_q <= '0;
            stage_q <= '0;
            last_q  <= 1'b0;
            data_q  <= pc2({c_nxt, d_nxt});
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_q) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q <= pc2({c_nxt, d_nxt});
              last_q <= (round_q == 4'd14) && (stage_q == 2'(NUM_KEYS - 1));
              if (round_q == 4'd15) begin
                round_q <= '0;
                stage_q <= stage_q + 2'd1;
                dir_q   <= ld_dir;
              end else begin
                round_q <= round_q + 4'd1;
              end
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = valid_q;
  assign bus.rk_data  = data_q;
  assign bus.rk_round = round_q;
  assign bus.rk_stage = stage_q;
  assign bus.rk_last  = last_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_des_key_sched_iter.sv
// -----------------------------------------------------------------------------
// tb_des_key_sched_iter
// Drives a single-DES and a 3DES instance of des_key_sched_iter. Expected round
// keys come from a direct DES key-schedule model: K(n) = PC2 of C0/D0 rotated
// by the cumulative shift count, with the per-stage key/order mapping applied
// per job. Known-answer table for key 0123456789ABCDEF plus random jobs with
// stalls and input disturbance, and a mid-job reset.
// -----------------------------------------------------------------------------
module tb_des_key_sched_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;          // 0 = single-DES instance, 1 = 3DES instance
  logic         start_in;
  logic         mode_in;
  logic [191:0] key_all;
  logic         rk_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] cap [48];      // keys accepted during the latest job

  always #5 clk = ~clk;

  des_key_sched_iter_if #(.NUM_KEYS(1)) if1 ();
  des_key_sched_iter_if #(.NUM_KEYS(3)) if3 ();

  assign if1.start    = start_in & ~sel;
  assign if1.mode     = mode_in;
  assign if1.key_in   = key_all[63:0];
  assign if1.rk_ready = rk_ready & ~sel;
  assign if3.start    = start_in & sel;
  assign if3.mode     = mode_in;
  assign if3.key_in   = key_all;
  assign if3.rk_ready = rk_ready & sel;

  des_key_sched_iter #(.NUM_KEYS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  des_key_sched_iter #(.NUM_KEYS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic        o_busy, o_valid, o_last, o_done;
  logic [47:0] o_data;
  logic [3:0]  o_round;
  logic [1:0]  o_stage;
  assign o_busy  = sel ? if3.busy     : if1.busy;
  assign o_valid = sel ? if3.rk_valid : if1.rk_valid;
  assign o_last  = sel ? if3.rk_last  : if1.rk_last;
  assign o_done  = sel ? if3.done     : if1.done;
  assign o_data  = sel ? if3.rk_data  : if1.rk_data;
  assign o_round = sel ? if3.rk_round : if1.rk_round;
  assign o_stage = sel ? if3.rk_stage : if1.rk_stage;

  // ---------------- reference model ----------------
  int T_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int T_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int T_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Round key K(n+1) for n = 0..15.
  function automatic logic [47:0] model_key(input logic [63:0] key, input int n);
    logic [55:0] cd;
    logic [55:0] cdr;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    int cum = 0;
    for (int j = 0; j < 56; j++) cd[55-j] = key[64-T_PC1[j]];
    for (int j = 0; j <= n; j++) cum += T_SHIFT[j];
    cum = cum % 28;
    c = cd[55:28];
    d = cd[27:0];
    c = (c << cum) | (c >> (28 - cum));
    d = (d << cum) | (d >> (28 - cum));
    cdr = {c, d};
    for (int j = 0; j < 48; j++) k[47-j] = cdr[56-T_PC2[j]];
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {63'd0, o_busy},  64'd0);
    check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    check({tag, "_data"},  {16'd0, o_data},  64'd0);
    check({tag, "_round"}, {60'd0, o_round}, 64'd0);
    check({tag, "_stage"}, {62'd0, o_stage}, 64'd0);
    check({tag, "_last"},  {63'd0, o_last},  64'd0);
    check({tag, "_done"},  {63'd0, o_done},  64'd0);
  endtask

  // Runs one job on the selected instance. stall_pct: chance of rk_ready low;
  // disturb: toggle start/mode/key_in during the job; abort_at >= 0: assert rst
  // while key index abort_at is presented.
  task automatic run_job(input int nk, input logic m, input logic [191:0] keys,
                         input int stall_pct, input bit disturb, input int abort_at);
    logic [47:0] exp_rk [48];
    logic [3:0]  exp_round [48];
    logic [1:0]  exp_stage [48];
    int total, idx, cyc, kidx;
    bit dec, rdy;
    total = 16 * nk;
    for (int s = 0; s < nk; s++) begin
      if (nk == 1)  begin kidx = 0;     dec = m;        end
      else if (!m)  begin kidx = s;     dec = (s == 1); end
      else          begin kidx = 2 - s; dec = (s != 1); end
      for (int r = 0; r < 16; r++) begin
        exp_rk[s*16+r]    = model_key(keys[64*kidx +: 64], dec ? 15 - r : r);
        exp_round[s*16+r] = 4'(r);
        exp_stage[s*16+r] = 2'(s);
      end
    end
    @(negedge clk);
    sel = (nk == 3);
    key_all = keys; mode_in = m; rk_ready = 1'b0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("busy_after_start", {63'd0, o_busy}, 64'd1);
    idx = 0;
    cyc = 0;
    while (idx < total) begin
      if (cyc > 2000) begin
        check("timeout_keys", 64'(idx), 64'(total));
        break;
      end
      check("rk_valid", {63'd0, o_valid}, 64'd1);
      check("rk_data",  {16'd0, o_data},  {16'd0, exp_rk[idx]});
      check("rk_round", {60'd0, o_round}, {60'd0, exp_round[idx]});
      check("rk_stage", {62'd0, o_stage}, {62'd0, exp_stage[idx]});
      check("rk_last",  {63'd0, o_last},  64'(idx == total - 1));
      check("no_done",  {63'd0, o_done},  64'd0);
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        rk_ready = 1'b0;
        start_in = 1'b0;
        repeat (20) begin
          @(negedge clk);
          check("abort_no_done", {63'd0, o_done}, 64'd0);
          check("abort_idle",    {62'd0, o_busy, o_valid}, 64'd0);
        end
        return;
      end
      rdy = ($urandom_range(99) >= 32'(stall_pct));
      if (disturb) begin
        start_in = 1'($urandom);
        mode_in  = 1'($urandom);
        key_all  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      rk_ready = rdy;
      if (rdy) begin
        cap[idx] = o_data;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (stall_pct == 0 && idx == total) check("keys_no_bubble_cycles", 64'(cyc), 64'(total));
    start_in = 1'b0;
    rk_ready = 1'b0;
    check("done_pulse",  {63'd0, o_done},  64'd1);
    check("done_valid0", {63'd0, o_valid}, 64'd0);
    check("done_busy1",  {63'd0, o_busy},  64'd1);
    @(negedge clk);
    check("end_done0", {63'd0, o_done}, 64'd0);
    check("end_busy0", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    check("no_second_job", {62'd0, o_busy, o_valid}, 64'd0);
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic        mode;
    int          pos;
    logic [47:0] rk;
  } vec_t;

  vec_t tbl [6];

  task automatic check_table(input logic m);
    for (int i = 0; i < 6; i++)
      if (tbl[i].mode == m)
        check($sformatf("kat_m%0d_pos%0d", m, tbl[i].pos), {16'd0, cap[tbl[i].pos]}, {16'd0, tbl[i].rk});
  endtask

  localparam logic [63:0] KAT_KEY = 64'h0123456789ABCDEF;

  initial begin
    tbl[0] = '{1'b0, 0,  48'h0B02679B49A5};
    tbl[1] = '{1'b0, 1,  48'h69A659256A26};
    tbl[2] = '{1'b0, 15, 48'hCA3D03B87032};
    tbl[3] = '{1'b1, 0,  48'hCA3D03B87032};
    tbl[4] = '{1'b1, 14, 48'h69A659256A26};
    tbl[5] = '{1'b1, 15, 48'h0B02679B49A5};

    rst = 1'b1; sel = 1'b0; start_in = 1'b0; mode_in = 1'b0; key_all = '0; rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset1");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset3");
    rst = 1'b0;
    @(negedge clk);

    run_job(1, 1'b0, {128'd0, KAT_KEY}, 0, 1'b0, -1);
    check_table(1'b0);
    run_job(1, 1'b1, {128'd0, KAT_KEY}, 0, 1'b0, -1);
    check_table(1'b1);
    run_job(1, 1'b0, {128'd0, KAT_KEY}, 40, 1'b1, -1);
    check_table(1'b0);
    run_job(3, 1'b0, {KAT_KEY, KAT_KEY, KAT_KEY}, 0, 1'b0, -1);
    run_job(3, 1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 30, 1'b1, -1);

    run_job(1, 1'b0, {128'd0, KAT_KEY}, 0, 1'b0, 7);
    run_job(1, 1'b0, {128'd0, KAT_KEY}, 0, 1'b0, -1);
    check_table(1'b0);
    run_job(3, 1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 20, 1'b0, 21);

    for (int i = 0; i < 8; i++)
      run_job((i % 2 == 0) ? 1 : 3, 1'($urandom),
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(60)), 1'($urandom), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_sched_iter.md
# des_key_sched_iter

Iterative, back-pressured DES round-key generator that replaces the fully unrolled combinational key schedule in the cipher datapath. It captures a 64-bit key, or a three-key 3DES bundle, on a start handshake. It then streams one 48-bit round key per accepted transfer, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits between the key-load logic and an iterative DES/3DES round engine, which consumes one key per round.

## Interface
- NUM_KEYS, default 1: 1 = single DES (16 keys per job); 3 = 3DES EDE (48 keys per job). Other values are illegal.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted only when busy=0
- mode  in  1  0 = encrypt order, 1 = decrypt order; sampled with start
- key_in  in  64*NUM_KEYS  key_in[64*k +: 64] is key k+1; parity bits ignored; sampled with start
- busy  out  1  job in progress
- rk_valid  out  1  rk_data holds a valid round key
- rk_ready  in  1  consumer accepts the key when rk_valid && rk_ready
- rk_data  out  48  round key, PC-2 output, MSB = PC-2 bit 1
- rk_round  out  4  round index 0..15 within the current stage (0 = first round applied)
- rk_stage  out  2  3DES stage 0..2; always 0 when NUM_KEYS=1
- rk_last  out  1  high with the final key of the job
- done  out  1  one-cycle pulse after the final key is accepted

## Operation
- Shift schedule is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C/D halves are 28 bits each; PC-1 produces C0/D0.
- Encrypt stage: state is loaded with rotl(C0,1)/rotl(D0,1). Output is PC2(C,D). On each accepted key i, state rotates left by shift[i+1].
- Decrypt stage: state is loaded with C0/D0, which equals C16/D16. Output is PC2(C,D) = K16. On each accepted key with rk_round=r, state rotates right by shift[15-r].
- NUM_KEYS=1: one stage, using key 1 in the order given by mode.
- NUM_KEYS=3, mode=0: stage 0 is key 1 encrypt order, stage 1 is key 2 decrypt order, stage 2 is key 3 encrypt order.
- NUM_KEYS=3, mode=1: stage 0 is key 3 decrypt order, stage 1 is key 2 encrypt order, stage 2 is key 1 decrypt order.
- The full key_in and mode are registered at start. Later changes to the inputs have no effect on the running job.
- FSM states:
  - IDLE: start accepted → RUN.
  - RUN: accepted key with rk_round=15 and not the last stage → load the next stage's C0/D0, stay in RUN; accepted key with rk_last → DONE.
  - DONE: one cycle, done=1 → IDLE.
- rk_last = (rk_round==15) && (rk_stage==NUM_KEYS-1).
- start while busy=1 is ignored, with no queuing. This includes the cycle in which the final key is accepted.
- Reset asserted mid-job aborts the job immediately. The block returns to IDLE and no done pulse is generated.

## Timing
- Reset values: busy=0, rk_valid=0, rk_data=0, rk_round=0, rk_stage=0, rk_last=0, done=0.
- Start accepted in cycle T (start && !busy): busy=1 and rk_valid=1 from T+1, with the first key presented at T+1.
- Outputs are registered. rk_data, rk_round, rk_stage and rk_last hold stable while rk_valid && !rk_ready.
- After an accepted transfer in cycle N, the next key is presented in N+1, including across a stage boundary, with no bubble.
- Final key accepted in cycle L: at L+1, rk_valid=0 and done=1 while busy stays 1. At L+2, busy=0, and a new start may be accepted there.
- With rk_ready held high, a job occupies 16*NUM_KEYS+2 cycles from start acceptance to busy falling.
- rk_valid stays high from T+1 through the cycle the final key is accepted.

## Structure
- Package des_pkg holds:
  - PC1 and PC2 permutation functions.
  - SHIFT_SCHED constant array (16 x 2 bits).
  - rotl28/rotr28 functions.
  - Mode encodings (MODE_ENC=0, MODE_DEC=1).
  - FSM state typedef.
- One sub-module, des_ks_core: the C/D registers, load, and left/right rotate by 1 or 2. The top level owns the FSM, stage sequencing, key selection and the handshake.

## Test plan
- NUM_KEYS=1, mode=0, key 0123456789ABCDEF, rk_ready=1 → 16 keys on consecutive cycles. First key is 0B02679B49A5, second is 69A659256A26, last is CA3D03B87032. rk_last on the 16th key, done at T+17, busy low at T+18.
- NUM_KEYS=1, mode=1, same key → exact reverse sequence: first CA3D03B87032, last 0B02679B49A5.
- Random rk_ready stalls, plus start pulsed and key_in changed mid-job → key sequence identical to the no-stall case; rk_data stable during stalls; no second job started.
- NUM_KEYS=3, mode=0, keys 1, 2, 3 all 0123456789ABCDEF → 48 keys: forward 16, reverse 16, forward 16. rk_stage steps 0→1→2 with no bubble at the boundaries.
- rst asserted at key 7 of a job → all outputs at reset values immediately. No done pulse. The next start yields the full correct sequence from K1.
